// File: rtl/div_clock_monitor.sv
// rtl/div_clock_monitor.sv - measures period and high time of a divided clock in the clk domain
// Flags ratio/duty errors and loss of toggling, and reports lock after consecutive good periods.
module div_clock_monitor #(
   parameter int DIV_N       = 5,
   parameter int PER_TOL     = 0,
   parameter int DUTY_TOL    = 1,
   parameter int LOCK_CNT    = 4,
   parameter int TIMEOUT     = 64,
   parameter int CNT_W       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_div,
   input  logic             enable,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             meas_valid,
   output logic             err,
   output logic [15:0]      err_cnt,
   output logic             timeout,
   output logic             locked
);
   localparam int SS   = (SYNC_STAGES < 1) ? 1 : SYNC_STAGES;
   localparam int GC_W = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0]        CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]        TO_VAL  = CNT_W'(TIMEOUT);
   localparam logic [GC_W-1:0]         LOCK_V  = GC_W'(LOCK_CNT);
   localparam logic signed [CNT_W:0]   DIV_V   = (CNT_W+1)'(DIV_N);
   localparam logic signed [CNT_W:0]   PTOL_V  = (CNT_W+1)'(PER_TOL);
   localparam logic signed [CNT_W:0]   DTOL_V  = (CNT_W+1)'(DUTY_TOL);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
   state_t state;

   logic [SS-1:0]         sync_q;
   logic                  s_d;
   logic                  s;
   logic                  rise;
   logic                  fall;
   logic [CNT_W-1:0]      hi_cnt;
   logic [CNT_W-1:0]      lo_cnt;
   logic [CNT_W-1:0]      hi_inc;
   logic [CNT_W-1:0]      lo_inc;
   logic [GC_W-1:0]       good_cnt;
   logic signed [CNT_W:0] per_dev;
   logic signed [CNT_W:0] duty_dev;
   logic signed [CNT_W:0] per_abs;
   logic signed [CNT_W:0] duty_abs;
   logic                  good;
   logic                  to_hit;

   assign s      = sync_q[SS-1];
   assign rise   = s & ~s_d;
   assign fall   = ~s & s_d;
   assign hi_inc = (hi_cnt == CNT_MAX) ? hi_cnt : hi_cnt + CNT_W'(1);
   assign lo_inc = (lo_cnt == CNT_MAX) ? lo_cnt : lo_cnt + CNT_W'(1);

   assign per_dev  = $signed({1'b0, hi_cnt}) + $signed({1'b0, lo_cnt}) - DIV_V;
   assign duty_dev = $signed({1'b0, hi_cnt}) - $signed({1'b0, lo_cnt});
   assign per_abs  = per_dev[CNT_W]  ? -per_dev  : per_dev;
   assign duty_abs = duty_dev[CNT_W] ? -duty_dev : duty_dev;
   assign good     = (per_abs <= PTOL_V) && (duty_abs <= DTOL_V);

   // A run that has already counted TIMEOUT cycles ends the measurement, even if an edge arrives now.
   assign to_hit = ((state == HIGH) && (hi_cnt >= TO_VAL)) ||
                   ((state == LOW)  && (lo_cnt >= TO_VAL));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         s_d    <= 1'b0;
      end else begin
         sync_q[0] <= clk_div;
         for (int i = 1; i < SS; i++) sync_q[i] <= sync_q[i-1];
         s_d <= s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         hi_cnt     <= '0;
         lo_cnt     <= '0;
         good_cnt   <= '0;
         period     <= '0;
         high_time  <= '0;
         meas_valid <= 1'b0;
         err        <= 1'b0;
         err_cnt    <= '0;
         timeout    <= 1'b0;
         locked     <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         err        <= 1'b0;
         // lock follows the good-period count one cycle after it saturates
         locked     <= (good_cnt == LOCK_V);
         if (!enable) begin
            state    <= IDLE;
            hi_cnt   <= '0;
            lo_cnt   <= '0;
            good_cnt <= '0;
            locked   <= 1'b0;
            timeout  <= 1'b0;
         end else if (to_hit) begin
            state    <= IDLE;
            hi_cnt   <= '0;
            lo_cnt   <= '0;
            good_cnt <= '0;
            locked   <= 1'b0;
            timeout  <= 1'b1;
            err      <= 1'b1;
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
         end else begin
            case (state)
               IDLE: begin
                  if (rise) begin
                     state   <= HIGH;
                     hi_cnt  <= CNT_W'(1);
                     timeout <= 1'b0;
                  end
               end
               HIGH: begin
                  if (fall) begin
                     state  <= LOW;
                     lo_cnt <= CNT_W'(1);
                  end else begin
                     hi_cnt <= hi_inc;
                  end
               end
               LOW: begin
                  if (rise) begin
                     period     <= hi_cnt + lo_cnt;
                     high_time  <= hi_cnt;
                     meas_valid <= 1'b1;
                     state      <= HIGH;
                     hi_cnt     <= CNT_W'(1);
                     lo_cnt     <= '0;
                     if (good) begin
                        if (good_cnt != LOCK_V) good_cnt <= good_cnt + GC_W'(1);
                     end else begin
                        err      <= 1'b1;
                        locked   <= 1'b0;
                        good_cnt <= '0;
                        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                     end
                  end else begin
                     lo_cnt <= lo_inc;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_div_clock_monitor.sv
// tb/tb_div_clock_monitor.sv - bench for div_clock_monitor
// Drives clk_div as high/low runs and predicts each measurement from the run lengths.
module tb_div_clock_monitor;
   localparam int DIV_N       = 5;
   localparam int PER_TOL     = 0;
   localparam int DUTY_TOL    = 1;
   localparam int LOCK_CNT    = 4;
   localparam int TIMEOUT     = 64;
   localparam int CNT_W       = 8;
   localparam int SYNC_STAGES = 2;
   localparam int LAT         = SYNC_STAGES + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             clk_div;
   logic             enable;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             meas_valid;
   logic             err;
   logic [15:0]      err_cnt;
   logic             timeout;
   logic             locked;

   div_clock_monitor #(
      .DIV_N(DIV_N), .PER_TOL(PER_TOL), .DUTY_TOL(DUTY_TOL), .LOCK_CNT(LOCK_CNT),
      .TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk(clk), .rst(rst), .clk_div(clk_div), .enable(enable),
      .period(period), .high_time(high_time), .meas_valid(meas_valid), .err(err),
      .err_cnt(err_cnt), .timeout(timeout), .locked(locked)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int per;
      int hi;
      bit bad;
      bit lock;
      int at;
   } meas_t;

   meas_t expq[$];
   int    passed = 0;
   int    total = 0;
   bit    armed = 0;
   int    ph = 0;
   int    pl = 0;
   int    consec = 0;
   int    nerr = 0;
   int    last_per = 0;
   int    last_hi = 0;
   bit    lock_due = 0;
   bit    lock_exp = 0;
   int    err_only = 0;
   int    meas_seen = 0;

   function automatic bit is_bad(input int h, input int l);
      int dp;
      int dd;
      dp = h + l - DIV_N;
      dd = h - l;
      if (dp < 0) dp = -dp;
      if (dd < 0) dd = -dd;
      return (dp > PER_TOL) || (dd > DUTY_TOL);
   endfunction

   // A rise that follows a complete high+low pair publishes that pair.
   task automatic model_rise(input int h, input int l);
      meas_t m;
      if (armed) begin
         m.per = ph + pl;
         m.hi  = ph;
         m.bad = is_bad(ph, pl);
         if (m.bad) begin
            consec = 0;
            nerr++;
         end else begin
            consec++;
         end
         m.lock = (consec >= LOCK_CNT);
         m.at   = cyc + LAT;
         last_per = m.per;
         last_hi  = m.hi;
         expq.push_back(m);
      end
      armed = enable;
      ph = h;
      pl = l;
   endtask

   task automatic model_timeout();
      if (armed) nerr++;
      armed  = 0;
      consec = 0;
   endtask

   task automatic model_quiet();
      armed  = 0;
      consec = 0;
   endtask

   task automatic tick();
      meas_t m;
      @(posedge clk);
      #1;
      if (lock_due) begin
         lock_due = 0;
         total++;
         if (locked !== lock_exp)
            $display("FAIL lock_after_meas cyc=%0d locked=%b required=%b", cyc, locked, lock_exp);
         else passed++;
      end
      if (err === 1'b1 && meas_valid !== 1'b1) err_only++;
      if (meas_valid === 1'b1) begin
         meas_seen++;
         total++;
         if (expq.size() == 0) begin
            $display("FAIL meas_unexpected cyc=%0d period=%0d high_time=%0d required no pulse",
                     cyc, period, high_time);
         end else begin
            m = expq.pop_front();
            if (cyc !== m.at || period !== CNT_W'(m.per) || high_time !== CNT_W'(m.hi) || err !== m.bad)
               $display("FAIL meas cyc=%0d period=%0d high_time=%0d err=%b required cyc=%0d period=%0d high_time=%0d err=%b",
                        cyc, period, high_time, err, m.at, m.per, m.hi, m.bad);
            else passed++;
            lock_due = 1;
            lock_exp = m.lock;
         end
      end
      if (expq.size() > 0 && expq[0].at < cyc) begin
         total++;
         m = expq.pop_front();
         $display("FAIL meas_missing cyc=%0d got no pulse, required pulse at cyc=%0d period=%0d", cyc, m.at, m.per);
      end
   endtask

   task automatic hold(input logic v, input int n);
      clk_div = v;
      repeat (n) tick();
   endtask

   task automatic drive_cycle(input int h, input int l);
      model_rise(h, l);
      hold(1'b1, h);
      if (h >= TIMEOUT) model_timeout();
      hold(1'b0, l);
      if (l >= TIMEOUT) model_timeout();
   endtask

   task automatic test_reset();
      int ms;
      rst = 1'b1;
      enable = 1'b1;
      clk_div = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         clk_div = ~clk_div;
      end
      total++;
      if ({period, high_time, meas_valid, err, err_cnt, timeout, locked} !== '0)
         $display("FAIL reset_hold period=%0d high_time=%0d err_cnt=%0d locked=%b timeout=%b required all 0",
                  period, high_time, err_cnt, locked, timeout);
      else passed++;
      clk_div = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (6) drive_cycle(3, 2);
      drive_cycle(3, 3);
      model_rise(3, 2);
      hold(1'b1, 3);
      hold(1'b0, 1);
      total++;
      if (err_cnt !== 16'(nerr) || period !== 8'd6)
         $display("FAIL pre_reset err_cnt=%0d period=%0d required err_cnt=%0d period=6", err_cnt, period, nerr);
      else passed++;
      #2 rst = 1'b1;
      #1;
      total++;
      if (period !== '0 || high_time !== '0)
         $display("FAIL async_reset_meas period=%0d high_time=%0d required 0 0", period, high_time);
      else passed++;
      total++;
      if (err_cnt !== 16'd0)
         $display("FAIL async_reset_err_cnt err_cnt=%0d required 0", err_cnt);
      else passed++;
      total++;
      if ({meas_valid, err, timeout, locked} !== 4'b0000)
         $display("FAIL async_reset_flags meas_valid=%b err=%b timeout=%b locked=%b required 0000",
                  meas_valid, err, timeout, locked);
      else passed++;
      expq.delete();
      lock_due = 0;
      model_quiet();
      nerr = 0;
      clk_div = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      ms = meas_seen;
      drive_cycle(3, 2);
      total++;
      if (meas_seen != ms)
         $display("FAIL first_period_silent meas_count=%0d required %0d", meas_seen, ms);
      else passed++;
   endtask

   task automatic test_nominal();
      repeat (3) drive_cycle(3, 2);
      total++;
      if (locked !== 1'b0) $display("FAIL lock_after_3 locked=%b required 0", locked);
      else passed++;
      drive_cycle(3, 2);
      total++;
      if (locked !== 1'b1) $display("FAIL lock_after_4 locked=%b required 1", locked);
      else passed++;
      repeat (4) drive_cycle(3, 2);
      total++;
      if (err_cnt !== 16'd0 || err_only != 0)
         $display("FAIL nominal_no_err err_cnt=%0d timeout_errs=%0d required 0 0", err_cnt, err_only);
      else passed++;
   endtask

   task automatic test_period_glitch();
      int e0;
      repeat (5) drive_cycle(3, 2);
      e0 = nerr;
      drive_cycle(3, 3);
      drive_cycle(3, 2);
      total++;
      if (err_cnt !== 16'(e0 + 1) || locked !== 1'b0)
         $display("FAIL glitch err_cnt=%0d locked=%b required err_cnt=%0d locked=0", err_cnt, locked, e0 + 1);
      else passed++;
      repeat (3) drive_cycle(3, 2);
      total++;
      if (locked !== 1'b0) $display("FAIL relock_early locked=%b required 0", locked);
      else passed++;
      drive_cycle(3, 2);
      total++;
      if (locked !== 1'b1) $display("FAIL relock locked=%b required 1", locked);
      else passed++;
   endtask

   task automatic test_duty_error();
      int e0;
      e0 = nerr;
      drive_cycle(4, 1);
      drive_cycle(3, 2);
      total++;
      if (period !== 8'd5 || high_time !== 8'd4 || err_cnt !== 16'(e0 + 1) || locked !== 1'b0)
         $display("FAIL duty period=%0d high_time=%0d err_cnt=%0d locked=%b required 5 4 %0d 0",
                  period, high_time, err_cnt, locked, e0 + 1);
      else passed++;
   endtask

   task automatic test_random();
      int h;
      int l;
      int eo;
      eo = err_only;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) != 0) begin
            h = $urandom_range(2, 3);
            l = 5 - h;
         end else begin
            h = $urandom_range(1, 6);
            l = $urandom_range(1, 6);
         end
         drive_cycle(h, l);
      end
      total++;
      if (err_cnt !== 16'(nerr) || err_only != eo || locked !== (consec >= LOCK_CNT))
         $display("FAIL random_totals err_cnt=%0d timeout_errs=%0d locked=%b required %0d %0d %b",
                  err_cnt, err_only - eo, locked, nerr, 0, consec >= LOCK_CNT);
      else passed++;
   endtask

   task automatic test_stuck_low();
      int f;
      int r;
      int to_at;
      int eo;
      repeat (5) drive_cycle(3, 2);
      model_rise(3, 100);
      hold(1'b1, 3);
      f = cyc;
      clk_div = 1'b0;
      eo = err_only;
      to_at = -1;
      repeat (100) begin
         tick();
         if (timeout === 1'b1 && to_at < 0) to_at = cyc;
      end
      model_timeout();
      // low count reaches TIMEOUT, then the next count flags it
      total++;
      if (to_at != f + LAT + TIMEOUT)
         $display("FAIL timeout_cycle cyc=%0d required %0d", to_at, f + LAT + TIMEOUT);
      else passed++;
      total++;
      if (err_only - eo != 1 || err_cnt !== 16'(nerr) || locked !== 1'b0 || timeout !== 1'b1)
         $display("FAIL timeout_effects err_pulses=%0d err_cnt=%0d locked=%b timeout=%b required 1 %0d 0 1",
                  err_only - eo, err_cnt, locked, timeout, nerr);
      else passed++;
      model_rise(3, 2);
      r = cyc;
      clk_div = 1'b1;
      tick();
      tick();
      total++;
      if (timeout !== 1'b1) $display("FAIL timeout_held cyc=%0d timeout=%b required 1", cyc, timeout);
      else passed++;
      tick();
      total++;
      if (timeout !== 1'b0 || cyc != r + LAT)
         $display("FAIL timeout_clear cyc=%0d timeout=%b required cyc=%0d timeout=0", cyc, timeout, r + LAT);
      else passed++;
      hold(1'b0, 2);
      repeat (5) drive_cycle(3, 2);
   endtask

   task automatic test_enable_drop();
      int eo;
      eo = err_only;
      repeat (5) drive_cycle(3, 2);
      model_rise(20, 2);
      hold(1'b1, 5);
      enable = 1'b0;
      model_quiet();
      repeat (3) tick();
      total++;
      if (locked !== 1'b0 || timeout !== 1'b0 || period !== CNT_W'(last_per) || high_time !== CNT_W'(last_hi))
         $display("FAIL enable_drop locked=%b timeout=%b period=%0d high_time=%0d required 0 0 %0d %0d",
                  locked, timeout, period, high_time, last_per, last_hi);
      else passed++;
      enable = 1'b1;
      hold(1'b1, 12);
      hold(1'b0, 2);
      repeat (6) drive_cycle(3, 2);
      total++;
      if (err_only != eo || err_cnt !== 16'(nerr) || locked !== 1'b1)
         $display("FAIL enable_resume err_pulses=%0d err_cnt=%0d locked=%b required 0 %0d 1",
                  err_only - eo, err_cnt, locked, nerr);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_period_glitch();
      test_duty_error();
      test_random();
      test_stuck_low();
      test_enable_drop();
      repeat (LAT + 2) tick();
      total++;
      if (expq.size() != 0) $display("FAIL meas_drain pending=%0d required 0", expq.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d required finish before time limit", cyc);
      $fatal(1, "watchdog");
   end
endmodule
